// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: sequences rounds, resets the playfield between
// rounds, gates player keys, keeps round-win tallies and declares the match winner.
module tow_match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 3,
    parameter int CLEAR_CYCLES = 4,
    parameter int SHOW_CYCLES  = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic               L_in_i,
    input  logic               R_in_i,
    input  logic [1:0]         winner_i,
    output logic               pf_reset_o,
    output logic               L_out_o,
    output logic               R_out_o,
    output logic [SCORE_W-1:0] left_score_o,
    output logic [SCORE_W-1:0] right_score_o,
    output logic               match_over_o,
    output logic [1:0]         match_winner_o
);

    localparam int CNT_MAX = (SHOW_CYCLES > CLEAR_CYCLES) ? SHOW_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PLAY, S_SCORE_L, S_SCORE_R, S_SHOW, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] left_q, left_d, right_q, right_d;
    logic [1:0]         mw_q, mw_d;

    // Saturating increment: a score that has reached WIN_SCORE never moves again.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? WIN : s + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            mw_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            mw_q    <= mw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        left_d  = left_q;
        right_d = right_q;
        mw_d    = mw_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    left_d  = '0;
                    right_d = '0;
                    mw_d    = 2'b00;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLEAR_LAST) state_d = S_PLAY;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            S_PLAY: begin
                // Both 00 and the invalid 11 keep the round running.
                if (winner_i == 2'b01)      state_d = S_SCORE_L;
                else if (winner_i == 2'b10) state_d = S_SCORE_R;
            end
            S_SCORE_L: begin
                left_d = sat_inc(left_q);
                if (left_d == WIN) begin
                    mw_d    = 2'b01;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_SCORE_R: begin
                right_d = sat_inc(right_q);
                if (right_d == WIN) begin
                    mw_d    = 2'b10;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) state_d = S_CLEAR;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pf_reset_o     = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign L_out_o        = (state_q == S_PLAY) && L_in_i;
    assign R_out_o        = (state_q == S_PLAY) && R_in_i;
    assign left_score_o   = left_q;
    assign right_score_o  = right_q;
    assign match_over_o   = (state_q == S_DONE);
    assign match_winner_o = mw_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Scoreboard bench for tow_match_ctrl: scripted matches with randomized keys,
// winner noise and play lengths, checked cycle by cycle against a round-level model.
module tb_tow_match_ctrl;

    localparam int WIN = 7;
    localparam int SW  = 3;
    localparam int CLR = 4;
    localparam int SHW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          li = 1'b0;
    logic          ri = 1'b0;
    logic [1:0]    win = 2'b00;
    logic          pf, lo, ro, over;
    logic [SW-1:0] ls, rs;
    logic [1:0]    mw;

    tow_match_ctrl #(
        .WIN_SCORE(WIN), .SCORE_W(SW), .CLEAR_CYCLES(CLR), .SHOW_CYCLES(SHW)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .L_in_i(li), .R_in_i(ri),
        .winner_i(win), .pf_reset_o(pf), .L_out_o(lo), .R_out_o(ro),
        .left_score_o(ls), .right_score_o(rs), .match_over_o(over),
        .match_winner_o(mw)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pf;
        logic          lo;
        logic          ro;
        logic [SW-1:0] ls;
        logic [SW-1:0] rs;
        logic          over;
        logic [1:0]    mw;
    } obs_t;

    obs_t q[$];
    obs_t me, mg;
    int   checks = 0;
    int   errors = 0;

    // Match-level model state: tallies, winner and whether the match is over.
    logic [SW-1:0] ls_m = '0;
    logic [SW-1:0] rs_m = '0;
    logic [1:0]    mw_m = 2'b00;
    logic          over_m = 1'b0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] rw();
        return 2'($urandom_range(0, 3));
    endfunction

    // One cycle: drive inputs just after the edge, queue what the outputs must read.
    task automatic cyc(input logic rstv, input logic l, input logic r,
                       input logic [1:0] w, input logic st,
                       input logic epf, input logic el, input logic er);
        obs_t e;
        @(posedge clk);
        #1;
        rst_n = rstv;
        li    = l;
        ri    = r;
        win   = w;
        start = st;
        e.pf = epf; e.lo = el; e.ro = er;
        e.ls = ls_m; e.rs = rs_m; e.over = over_m; e.mw = mw_m;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            mg = '{pf: pf, lo: lo, ro: ro, ls: ls, rs: rs, over: over, mw: mw};
            checks++;
            if (mg !== me) begin
                errors++;
                $display("FAIL outputs t=%0t got pf=%b lo=%b ro=%b ls=%0d rs=%0d over=%b mw=%b required pf=%b lo=%b ro=%b ls=%0d rs=%0d over=%b mw=%b",
                         $time, mg.pf, mg.lo, mg.ro, mg.ls, mg.rs, mg.over, mg.mw,
                         me.pf, me.lo, me.ro, me.ls, me.rs, me.over, me.mw);
            end
        end
    end

    task automatic reset_cycle();
        ls_m = '0; rs_m = '0; mw_m = 2'b00; over_m = 1'b0;
        cyc(1'b0, rb(), rb(), rw(), rb(), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cyc(1'b1, rb(), rb(), rw(), 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic done_cycles(input int n);
        repeat (n) cyc(1'b1, rb(), rb(), rw(), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_phase();
        repeat (CLR) cyc(1'b1, rb(), rb(), rw(), rb(), 1'b1, 1'b0, 1'b0);
    endtask

    // Start from IDLE (playfield held in reset) or DONE (not), then the clear phase.
    task automatic do_start();
        cyc(1'b1, rb(), rb(), rw(), 1'b1, !over_m, 1'b0, 1'b0);
        ls_m = '0; rs_m = '0; mw_m = 2'b00; over_m = 1'b0;
        clear_phase();
    endtask

    // One round won by 'who' (1 left, 2 right) after n undecided play cycles.
    // abort_at >= 0 drops reset that many cycles into the show phase.
    task automatic play_round(input int who, input int n, input bit hold11,
                              input int abort_at);
        logic l, r;
        logic [1:0] w;
        for (int i = 0; i < n; i++) begin
            l = rb(); r = rb();
            w = (hold11 || rb()) ? 2'b11 : 2'b00;
            cyc(1'b1, l, r, w, rb(), 1'b0, l, r);
        end
        cyc(1'b1, 1'b0, 1'b0, 2'(who), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, rb(), rb(), rw(), rb(), 1'b0, 1'b0, 1'b0);
        if (who == 1) ls_m = ls_m + 1'b1;
        else          rs_m = rs_m + 1'b1;
        if (ls_m == SW'(WIN) || rs_m == SW'(WIN)) begin
            over_m = 1'b1;
            mw_m   = 2'(who);
            return;
        end
        for (int i = 0; i < SHW; i++) begin
            if (i == abort_at) begin
                reset_cycle();
                return;
            end
            cyc(1'b1, rb(), rb(), rw(), rb(), 1'b0, 1'b0, 1'b0);
        end
        clear_phase();
    endtask

    initial begin
        repeat (3) reset_cycle();
        idle_cycles(6);

        do_start();
        play_round(1, 10, 1'b1, -1);
        for (int i = 0; i < 6; i++) play_round(1, int'($urandom_range(0, 6)), 1'b0, -1);
        done_cycles(6);

        do_start();
        for (int i = 0; i < 6; i++) begin
            play_round(1, int'($urandom_range(0, 5)), 1'b0, -1);
            play_round(2, int'($urandom_range(0, 5)), 1'b0, -1);
        end
        play_round(2, 3, 1'b0, -1);
        done_cycles(4);

        do_start();
        play_round(1, 2, 1'b0, -1);
        play_round(1, 1, 1'b0, -1);
        play_round(1, 0, 1'b0, -1);
        play_round(2, 2, 1'b0, -1);
        play_round(2, 3, 1'b0, 3);
        reset_cycle();
        idle_cycles(4);

        do_start();
        for (int i = 0; i < 2; i++) play_round(1 + int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0, -1);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
